// File: rtl/ntt_bfu_sched_if.sv
// ntt_bfu_sched_if: bundle between the NTT stage sequencer and its
// surroundings (controller handshake, coefficient RAM / twiddle ROM read
// side, BFU mode select, coefficient RAM write side).
//   master : controller/memory side (drives start/mode, observes the rest)
//   slave  : the sequencer (receives start/mode, drives addresses/strobes)
interface ntt_bfu_sched_if #(
    parameter int LOGN = 8
);
    logic            start;
    logic            mode;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [LOGN-1:0] rd_addr_a;
    logic [LOGN-1:0] rd_addr_b;
    logic [LOGN:0]   tw_addr;
    logic            bfu_sel;
    logic            wr_en;
    logic [LOGN-1:0] wr_addr_a;
    logic [LOGN-1:0] wr_addr_b;

    modport master (
        output start, mode,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  bfu_sel, wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        input  start, mode,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output bfu_sel, wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ntt_bfu_sched.sv
// ntt_bfu_sched: stage/address sequencer for one NTT (CT, mode 0) or INTT
// (GS, mode 1) pass over a coefficient RAM through a single pipelined BFU.
// One butterfly is issued per cycle; results are written back in place
// L = RD_LAT + BFU_LAT cycles later. Each stage is followed by L drain
// cycles so the next stage never reads a location still in flight.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (aborts a running transform)
//   bus  - slave side of ntt_bfu_sched_if: start/mode in; busy, done,
//          rd_en, rd_addr_a/b, tw_addr, bfu_sel, wr_en, wr_addr_a/b out
module ntt_bfu_sched #(
    parameter int LOGN    = 8,
    parameter int BFU_LAT = 4,
    parameter int RD_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    ntt_bfu_sched_if.slave      bus
);
    localparam int L  = RD_LAT + BFU_LAT;
    localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int KW = LOGN - 1;
    localparam int DW = $clog2(L + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [KW-1:0]   k_q, k_d;
    logic [DW-1:0]   dc_q, dc_d;
    logic            mode_q, mode_d;

    logic            rd_en;
    logic [LOGN-1:0] rd_a, rd_b, tw_idx;

    // write-back delay line: valid bit plus the address pair
    logic [L-1:0]             vld_pipe;
    logic [L-1:0][LOGN-1:0]   a_pipe, b_pipe;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            dc_q    <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            dc_q    <= dc_d;
            mode_q  <= mode_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        dc_d    = dc_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    s_d     = '0;
                    k_d     = '0;
                    dc_d    = '0;
                    mode_d  = bus.mode;
                end
            end
            RUN: begin
                if (k_q == '1) begin
                    state_d = DRAIN;
                    k_d     = '0;
                    dc_d    = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                if (dc_q == DW'(L - 1)) begin
                    dc_d = '0;
                    k_d  = '0;
                    if (s_q == SW'(LOGN - 1)) begin
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                        s_d     = s_q + 1'b1;
                    end
                end else begin
                    dc_d = dc_q + 1'b1;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- issue address generation ----------------
    // Both modes reduce to one form in sh = log2(half):
    //   CT : sh = LOGN-1-s,  GS : sh = s
    //   a  = (grp << (sh+1)) | off,  b = a + (1 << sh)
    //   tw = (1 << (LOGN-1-sh)) + grp
    always_comb begin
        logic [SW-1:0]   sh;
        logic [LOGN-1:0] kx, grp, off, mask, a, b, tw;
        sh     = mode_q ? s_q : (SW'(LOGN - 1) - s_q);
        kx     = {1'b0, k_q};
        grp    = kx >> sh;
        mask   = (LOGN'(1) << sh) - LOGN'(1);
        off    = kx & mask;
        a      = ((grp << sh) << 1) | off;
        b      = a + (LOGN'(1) << sh);
        tw     = (LOGN'(1) << (SW'(LOGN - 1) - sh)) + grp;
        rd_en  = (state_q == RUN);
        rd_a   = rd_en ? a  : '0;
        rd_b   = rd_en ? b  : '0;
        tw_idx = rd_en ? tw : '0;
    end

    // ---------------- write-back delay ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            a_pipe   <= '0;
            b_pipe   <= '0;
        end else begin
            vld_pipe[0] <= rd_en;
            a_pipe[0]   <= rd_a;
            b_pipe[0]   <= rd_b;
            for (int i = 1; i < L; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a_pipe[i]   <= a_pipe[i-1];
                b_pipe[i]   <= b_pipe[i-1];
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.busy      = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done      = (state_q == FIN);
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr_a = rd_a;
    assign bus.rd_addr_b = rd_b;
    assign bus.tw_addr   = rd_en ? {mode_q, tw_idx} : '0;
    // BFU operands arrive RD_LAT cycles after the read strobe
    assign bus.bfu_sel   = mode_q & vld_pipe[RD_LAT-1];
    assign bus.wr_en     = vld_pipe[L-1];
    assign bus.wr_addr_a = a_pipe[L-1];
    assign bus.wr_addr_b = b_pipe[L-1];
endmodule

// File: tb/tb_ntt_bfu_sched.sv
module tb_ntt_bfu_sched;
    localparam int LOGN = 8;
    localparam int N    = 1 << LOGN;
    localparam int L    = 5;
    localparam int SPAN = N / 2 + L;
    localparam int TOT  = LOGN * SPAN;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_bfu_sched_if #(.LOGN(LOGN)) bus ();

    ntt_bfu_sched #(.LOGN(LOGN), .BFU_LAT(4), .RD_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.busy, bus.done, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b,
                    bus.tw_addr, bus.bfu_sel, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b});
    endfunction

    // Reference butterfly addressing straight from the transform definition.
    function automatic void issue(input int s, input int k, input logic m,
                                  output int a, output int b, output int tw);
        int half, grp, off, idx;
        if (!m) begin
            half = N >> (s + 1);
            grp  = k >> (LOGN - 1 - s);
            idx  = (1 << s) + grp;
        end else begin
            half = 1 << s;
            grp  = k >> s;
            idx  = (N >> (s + 1)) + grp;
        end
        off = k & (half - 1);
        a   = grp * 2 * half + off;
        b   = a + half;
        tw  = (m ? N : 0) + idx;
    endfunction

    // cycle c (1-based after the accepted start edge) issues a butterfly?
    function automatic bit rd_at(input int c);
        return (c >= 1) && (c <= TOT) && (((c - 1) % SPAN) < N / 2);
    endfunction

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk(tag, 64'({bus.busy, bus.done, bus.rd_en, bus.wr_en}), 64'(0));
    endtask

    // One transform; start asserted in the current (idle) cycle.
    // abort_at > 0 applies rst after checking that cycle.
    task automatic run(input logic m, input int abort_at);
        int a, b, tw, stg, pos;
        int rd_cnt, wr_cnt, busy_cnt, done_cnt, done_c, last_wr, prev_stg, sp;
        rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0; done_c = 0;
        last_wr = 0; prev_stg = 0;
        sp = int'($urandom_range(20, TOT - 10));
        bus.start = 1'b1;
        bus.mode  = m;
        for (int c = 1; c <= TOT + 1; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.mode  = 1'($urandom);
            stg = (c - 1) / SPAN;
            pos = (c - 1) % SPAN;
            chk("ctrl", 64'({bus.busy, bus.done, bus.rd_en, bus.wr_en}),
                64'({c <= TOT, c == TOT + 1, rd_at(c), rd_at(c - L)}));
            if (rd_at(c)) begin
                issue(stg, pos, m, a, b, tw);
                chk("rd_addr", 64'({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr}),
                    64'({8'(a), 8'(b), 9'(tw)}));
            end
            if (rd_at(c - L)) begin
                issue((c - L - 1) / SPAN, (c - L - 1) % SPAN, m, a, b, tw);
                chk("wr_addr", 64'({bus.wr_addr_a, bus.wr_addr_b}), 64'({8'(a), 8'(b)}));
            end
            if (rd_at(c - 1))
                chk("bfu_sel", 64'(bus.bfu_sel), 64'(m));
            // directed anchor points
            if (!m && c == 1)
                chk("ntt_s0_first", 64'({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr}), {39'd0, 8'd0, 8'd128, 9'd1});
            if (!m && c == 2)
                chk("ntt_s0_second", 64'({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr}), {39'd0, 8'd1, 8'd129, 9'd1});
            if (!m && c == 7 * SPAN + 1)
                chk("ntt_s7_first", 64'({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr}), {39'd0, 8'd0, 8'd1, 9'd128});
            if (!m && c == 7 * SPAN + 128)
                chk("ntt_s7_last", 64'({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr}), {39'd0, 8'd254, 8'd255, 9'd255});
            if (m && c == 1)
                chk("intt_s0_first", 64'({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr}), {39'd0, 8'd0, 8'd1, 9'd384});
            if (m && c == 7 * SPAN + 1)
                chk("intt_s7_first", 64'({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr}), {39'd0, 8'd0, 8'd128, 9'd257});
            // observed bookkeeping
            if (bus.rd_en) begin
                rd_cnt++;
                if (stg != prev_stg) begin
                    chk("hazard", 64'(c > last_wr), 64'(1));
                    prev_stg = stg;
                end
            end
            if (bus.wr_en) begin
                wr_cnt++;
                last_wr = c;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_c = c;
            end
            if (c == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_outs", all_outs(), 64'(0));
                rst = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    chk("abort_quiet", 64'({bus.busy, bus.rd_en, bus.wr_en}), 64'(0));
                end
                return;
            end
            // starts while busy or in FIN must be ignored
            if (c == 10 || c == 600 || c == sp || c == TOT + 1) begin
                bus.start = 1'b1;
                bus.mode  = ~m;
            end
        end
        chk("rd_count", 64'(rd_cnt), 64'(LOGN * N / 2));
        chk("wr_count", 64'(wr_cnt), 64'(LOGN * N / 2));
        chk("busy_count", 64'(busy_cnt), 64'(1064));
        chk("done_count", 64'(done_cnt), 64'(1));
        chk("done_cycle", 64'(done_c), 64'(1065));
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outs", all_outs(), 64'(0));
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        idle_chk("idle_after_reset");

        run(1'b0, 0);                 // NTT, leaves start high in FIN
        idle_chk("idle_after_ntt");   // start still high -> accepted at done+1
        run(1'b1, 0);                 // INTT back-to-back
        idle_chk("idle_after_intt");
        bus.start = 1'b0;
        repeat (int'($urandom_range(1, 5))) idle_chk("idle_gap");

        run(1'($urandom), 300);       // aborted by reset
        run(1'($urandom), 0);         // fresh full run
        idle_chk("idle_final");
        bus.start = 1'b0;
        idle_chk("idle_final2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
